// File: rtl/pet_pkg.sv
// Shared PET constants and the PRG loader state encoding.
package pet_pkg;

  localparam logic [15:0] PET_RAM_TOP       = 16'h8000;
  localparam logic [7:0]  PET_BASIC4_VARTAB = 8'h2A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_FIX,
    ST_FIN
  } prg_state_t;

endpackage

// File: rtl/pet_prg_loader.sv
// PRG file DMA loader: parses the load address and writes the payload into PET RAM.
// Define PET_PRG_PTR_FIXUP_EN to patch the BASIC 4 VARTAB/ARYTAB/STREND pointers afterwards.
module pet_prg_loader
  import pet_pkg::*;
#(
`ifdef PET_PRG_PTR_FIXUP_EN
  parameter logic [7:0]  PTR_BASE = PET_BASIC4_VARTAB,
`endif
  parameter logic [15:0] RAM_TOP  = PET_RAM_TOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        busy,
  output logic        done,
  output logic        err_short,
  output logic        err_ovf
);

  prg_state_t  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic [7:0]  dma_din_q, dma_din_d;
  logic        dma_we_q, dma_we_d;
  logic        err_short_q, err_short_d;
  logic        err_ovf_q, err_ovf_d;
  logic        xfer;

`ifdef PET_PRG_PTR_FIXUP_EN
  logic [2:0]  fix_idx_q, fix_idx_d;
  logic [15:0] end_addr;

  // The address freezes once past the top, so clamping here yields the end pointer.
  assign end_addr = (addr_q >= RAM_TOP) ? RAM_TOP : addr_q;
`endif

  assign s_ready = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) || (state_q == ST_DATA);
  assign xfer    = s_valid && s_ready;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done    = (state_q == ST_FIN);

  assign dma_addr  = dma_addr_q;
  assign dma_din   = dma_din_q;
  assign dma_we    = dma_we_q;
  assign err_short = err_short_q;
  assign err_ovf   = err_ovf_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dma_addr_d  = dma_addr_q;
    dma_din_d   = dma_din_q;
    dma_we_d    = 1'b0;
    err_short_d = err_short_q;
    err_ovf_d   = err_ovf_q;
`ifdef PET_PRG_PTR_FIXUP_EN
    fix_idx_d   = fix_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_HDR_LO;
          err_short_d = 1'b0;
          err_ovf_d   = 1'b0;
        end
      end
      ST_HDR_LO: begin
        if (xfer) begin
          addr_d[7:0] = s_data;
          if (s_last) begin
            err_short_d = 1'b1;
            state_d     = ST_FIN;
          end else begin
            state_d = ST_HDR_HI;
          end
        end
      end
      ST_HDR_HI: begin
        if (xfer) begin
          addr_d[15:8] = s_data;
          if (s_last) begin
            err_short_d = 1'b1;
            state_d     = ST_FIN;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          if (addr_q < RAM_TOP) begin
            dma_we_d   = 1'b1;
            dma_addr_d = addr_q;
            dma_din_d  = s_data;
            addr_d     = addr_q + 16'd1;
          end else begin
            err_ovf_d = 1'b1;
          end
          if (s_last) begin
`ifdef PET_PRG_PTR_FIXUP_EN
            state_d   = ST_FIX;
            fix_idx_d = 3'd0;
`else
            state_d   = ST_FIN;
`endif
          end
        end
      end
      ST_FIX: begin
`ifdef PET_PRG_PTR_FIXUP_EN
        // Index 6 is a drain cycle so FIN lands one cycle after the sixth write.
        if (fix_idx_q == 3'd6) begin
          state_d = ST_FIN;
        end else begin
          dma_we_d   = 1'b1;
          dma_addr_d = {8'h00, PTR_BASE + {5'd0, fix_idx_q}};
          dma_din_d  = fix_idx_q[0] ? end_addr[15:8] : end_addr[7:0];
          fix_idx_d  = fix_idx_q + 3'd1;
        end
`else
        state_d = ST_FIN;
`endif
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= 16'h0000;
      dma_addr_q  <= 16'h0000;
      dma_din_q   <= 8'h00;
      dma_we_q    <= 1'b0;
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
`ifdef PET_PRG_PTR_FIXUP_EN
      fix_idx_q   <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dma_addr_q  <= dma_addr_d;
      dma_din_q   <= dma_din_d;
      dma_we_q    <= dma_we_d;
      err_short_q <= err_short_d;
      err_ovf_q   <= err_ovf_d;
`ifdef PET_PRG_PTR_FIXUP_EN
      fix_idx_q   <= fix_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_pet_prg_loader.sv
// Self-checking bench for pet_prg_loader: cycle-indexed expectation tables plus directed literal pins.
module tb_pet_prg_loader;

  localparam int          MAXC      = 12000;
  localparam logic [15:0] RAM_TOP_M = 16'h8000;
  localparam logic [7:0]  VARTAB_M  = 8'h2A;

  logic        clk = 1'b0;
  logic        reset, start, s_valid, s_last;
  logic [7:0]  s_data;
  logic        s_ready, dma_we, busy, done, err_short, err_ovf;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din;

  pet_prg_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
    .busy(busy), .done(done), .err_short(err_short), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  // Expected outputs per cycle; default zero is the idle/reset picture.
  bit          e_we[MAXC], e_busy[MAXC], e_ready[MAXC], e_done[MAXC], e_es[MAXC], e_eo[MAXC];
  logic [15:0] e_addr[MAXC];
  logic [7:0]  e_din[MAXC];

  typedef struct packed { logic [31:0] c; logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t         wlog[$];
  logic [15:0] ea[$];
  logic [7:0]  ed[$];
  logic [7:0]  q_b[$];
  int          q_g[$];
  int          cyc = 0, done_cyc = -1, checks = 0, errors = 0, n_loads = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic cmp();
    checks++;
    if (dma_we !== e_we[cyc] || (e_we[cyc] && (dma_addr !== e_addr[cyc] || dma_din !== e_din[cyc]))) begin
      errors++;
      $display("FAIL dma_write cyc=%0d got we=%b addr=%h din=%h expected we=%b addr=%h din=%h",
               cyc, dma_we, dma_addr, dma_din, e_we[cyc], e_addr[cyc], e_din[cyc]);
    end
    checks++;
    if ({busy, s_ready, done} !== {e_busy[cyc], e_ready[cyc], e_done[cyc]}) begin
      errors++;
      $display("FAIL ctrl cyc=%0d got busy/ready/done=%b%b%b expected=%b%b%b",
               cyc, busy, s_ready, done, e_busy[cyc], e_ready[cyc], e_done[cyc]);
    end
    checks++;
    if ({err_short, err_ovf} !== {e_es[cyc], e_eo[cyc]}) begin
      errors++;
      $display("FAIL err_flags cyc=%0d got short/ovf=%b%b expected=%b%b",
               cyc, err_short, err_ovf, e_es[cyc], e_eo[cyc]);
    end
    if (dma_we === 1'b1) wlog.push_back('{c: cyc, a: dma_addr, d: dma_din});
    if (done === 1'b1) done_cyc = cyc;
  endtask

  task automatic tick();
    @(negedge clk);
    cmp();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget got=%0d expected<%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic put_wr(input int c, input logic [15:0] a, input logic [7:0] d);
    if (c < MAXC) begin
      e_we[c] = 1'b1; e_addr[c] = a; e_din[c] = d;
    end
  endtask

  task automatic set_es(input int from, input bit v);
    for (int c = from; c < MAXC; c++) e_es[c] = v;
  endtask

  task automatic set_eo(input int from, input bit v);
    for (int c = from; c < MAXC; c++) e_eo[c] = v;
  endtask

  task automatic clear_from(input int from);
    for (int c = from; c < MAXC; c++) begin
      e_we[c] = 0; e_busy[c] = 0; e_ready[c] = 0; e_done[c] = 0; e_es[c] = 0; e_eo[c] = 0;
    end
  endtask

  task automatic clr();
    q_b.delete(); q_g.delete(); wlog.delete(); ea.delete(); ed.delete();
    done_cyc = -1;
  endtask

  task automatic add(input logic [7:0] b, input int g);
    q_b.push_back(b);
    q_g.push_back(g);
  endtask

  task automatic exp_w(input logic [15:0] a, input logic [7:0] d);
    ea.push_back(a);
    ed.push_back(d);
  endtask

  task automatic exp_fix(input logic [7:0] lo, input logic [7:0] hi);
`ifdef PET_PRG_PTR_FIXUP_EN
    for (int i = 0; i < 3; i++) begin
      exp_w(16'h002A + 16'(2 * i), lo);
      exp_w(16'h002B + 16'(2 * i), hi);
    end
`else
    if (lo === 8'hxx && hi === 8'hxx) exp_w(16'h0000, 8'h00);
`endif
  endtask

  task automatic check_log(input string nm);
    check({nm, "_count"}, wlog.size(), ea.size());
    if (wlog.size() == ea.size()) begin
      foreach (ea[i]) begin
        check({nm, "_addr"}, wlog[i].a, ea[i]);
        check({nm, "_data"}, wlog[i].d, ed[i]);
      end
    end
  endtask

  // Plans the whole load from the byte/gap lists, fills the expectation tables, then drives it.
  task automatic run_load(input int abort_at);
    int          S, N, D, L, c;
    int          acc[$];
    logic [15:0] addr, end_a;
    bit          ovf;
    L = q_b.size();
    S = cyc;
    c = S;
    for (int k = 0; k < L; k++) begin
      c = c + 1 + q_g[k];
      acc.push_back(c);
    end
    N = acc[L-1];
    set_es(S + 1, 1'b0);
    set_eo(S + 1, 1'b0);
    if (L <= 2) begin
      D = N + 1;
      set_es(D, 1'b1);
    end else begin
      addr = {q_b[1], q_b[0]};
      ovf  = 1'b0;
      for (int k = 2; k < L; k++) begin
        if (addr < RAM_TOP_M) begin
          put_wr(acc[k] + 1, addr, q_b[k]);
          addr = addr + 16'd1;
        end else if (!ovf) begin
          ovf = 1'b1;
          set_eo(acc[k] + 1, 1'b1);
        end
      end
      end_a = (addr > RAM_TOP_M) ? RAM_TOP_M : addr;
`ifdef PET_PRG_PTR_FIXUP_EN
      for (int i = 0; i < 6; i++)
        put_wr(N + 2 + i, {8'h00, VARTAB_M + 8'(i)}, (i % 2 == 1) ? end_a[15:8] : end_a[7:0]);
      D = N + 8;
`else
      D = N + 1;
`endif
    end
    for (int k = S + 1; k < D && k < MAXC; k++) e_busy[k] = 1'b1;
    for (int k = S + 1; k <= N && k < MAXC; k++) e_ready[k] = 1'b1;
    if (D < MAXC) e_done[D] = 1'b1;

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < L; k++) begin
      for (int g = 0; g < q_g[k]; g++) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        start   = ($urandom % 4 == 0);
        tick();
        start   = 1'b0;
      end
      s_valid = 1'b1;
      s_data  = q_b[k];
      s_last  = (k == L - 1);
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (k == abort_at) begin
        tick();
        reset = 1'b1;
        clear_from(cyc);
        #2;
        check("reset_mid_load_outputs",
              {dma_addr, dma_din, dma_we, s_ready, busy, done, err_short, err_ovf}, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_loads++;
        $display("load %0d: reset after byte %0d at cycle %0d", n_loads, k, cyc);
        return;
      end
    end
    while (cyc <= D) tick();
    n_loads++;
    $display("load %0d: %0d bytes, header %h%h, done at cycle %0d",
             n_loads, L, (L > 1) ? q_b[1] : 8'h00, q_b[0], D);
  endtask

  initial begin
    logic [15:0] la;
    int          len, mode;
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) tick();
    check("reset_outputs", {dma_addr, dma_din, dma_we, s_ready, busy, done, err_short, err_ovf}, 32'h0);
    reset = 1'b0;
    repeat (2) tick();

    // Basic load at $0401, back-to-back bytes.
    clr();
    add(8'h01, 0); add(8'h04, 0); add(8'hAA, 0); add(8'hBB, 0); add(8'hCC, 0);
    run_load(-1);
    exp_w(16'h0401, 8'hAA); exp_w(16'h0402, 8'hBB); exp_w(16'h0403, 8'hCC);
    exp_fix(8'h04, 8'h04);
    check_log("basic");
`ifdef PET_PRG_PTR_FIXUP_EN
    if (wlog.size() > 0) check("basic_done_latency", done_cyc - int'(wlog[0].c), 9);
`else
    if (wlog.size() > 0) check("basic_done_latency", done_cyc - int'(wlog[0].c), 2);
`endif

    // Payload crossing the top of RAM.
    clr();
    add(8'hFE, 0); add(8'h7F, 0); add(8'h11, 0); add(8'h22, 0); add(8'h33, 0); add(8'h44, 0);
    run_load(-1);
    exp_w(16'h7FFE, 8'h11); exp_w(16'h7FFF, 8'h22);
    exp_fix(8'h00, 8'h80);
    check_log("overflow");
    check("overflow_err_ovf", err_ovf, 1);
    check("overflow_err_short", err_short, 0);

    // File ending inside the header.
    clr();
    add(8'h01, 0);
    run_load(-1);
    check("short_writes", wlog.size(), 0);
    check("short_err", err_short, 1);
    check("short_done_seen", done_cyc >= 0, 1);

    // s_valid on every other cycle.
    clr();
    add(8'h01, 1); add(8'h04, 1); add(8'hAA, 1); add(8'hBB, 1); add(8'hCC, 1);
    run_load(-1);
    exp_w(16'h0401, 8'hAA); exp_w(16'h0402, 8'hBB); exp_w(16'h0403, 8'hCC);
    exp_fix(8'h04, 8'h04);
    check_log("gapped");
    if (wlog.size() >= 3) begin
      check("gapped_spacing1", wlog[1].c - wlog[0].c, 2);
      check("gapped_spacing2", wlog[2].c - wlog[1].c, 2);
    end

    // Single payload byte.
    clr();
    add(8'h01, 0); add(8'h04, 0); add(8'hAA, 0);
    run_load(-1);
    exp_w(16'h0401, 8'hAA);
    exp_fix(8'h02, 8'h04);
    check_log("single");
`ifdef PET_PRG_PTR_FIXUP_EN
    if (wlog.size() > 0) check("single_done_latency", done_cyc - int'(wlog[0].c), 7);
`else
    if (wlog.size() > 0) check("single_done_latency", done_cyc - int'(wlog[0].c), 0);
`endif

    // Reset after two payload bytes, then a clean reload.
    clr();
    add(8'h01, 0); add(8'h04, 0); add(8'hAA, 0); add(8'hBB, 0); add(8'hCC, 0); add(8'hDD, 0);
    run_load(3);
    exp_w(16'h0401, 8'hAA); exp_w(16'h0402, 8'hBB);
    check_log("aborted");
    clr();
    add(8'h00, 0); add(8'h05, 0); add(8'h77, 0);
    run_load(-1);
    exp_w(16'h0500, 8'h77);
    exp_fix(8'h01, 8'h05);
    check_log("reload");

    // Randomized loads against the expectation tables.
    for (int n = 0; n < 50; n++) begin
      clr();
      mode = $urandom_range(0, 5);
      if (mode <= 2)      la = 16'h0400 + 16'($urandom_range(0, 16'h7000));
      else if (mode <= 4) la = 16'h7FF0 + 16'($urandom_range(0, 15));
      else                la = 16'h8000 + 16'($urandom_range(0, 16'h7FFF));
      len = $urandom_range(1, 22);
      for (int k = 0; k < len; k++) begin
        if (k == 0)      add(la[7:0], $urandom_range(0, 2));
        else if (k == 1) add(la[15:8], ($urandom % 3 == 0) ? 1 : 0);
        else             add(8'($urandom), ($urandom % 3 == 0) ? $urandom_range(1, 3) : 0);
      end
      run_load(-1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
